// File: rtl/line_scheduler_if.sv
// Option-memory / line-solver handshake between the scheduler (master) and the solver side (slave).
interface line_scheduler_if #(
    parameter int SIZE   = 3,
    parameter int OPT_W  = 7,
    parameter int LINE_W = $clog2(2*SIZE)
);
    logic              opt_req;
    logic [LINE_W-1:0] opt_line;
    logic [OPT_W-1:0]  opt_idx;
    logic              res_valid;
    logic              res_keep;
    logic              cmp_we;
    logic [LINE_W-1:0] cmp_line;
    logic [OPT_W-1:0]  cmp_src;
    logic [OPT_W-1:0]  cmp_dst;
    logic              commit;
    logic [LINE_W-1:0] commit_line;
    logic [OPT_W-1:0]  commit_count;
    logic              mask_valid;
    logic [2*SIZE-1:0] mask;

    modport master (
        output opt_req, opt_line, opt_idx, cmp_we, cmp_line, cmp_src, cmp_dst,
               commit, commit_line, commit_count,
        input  res_valid, res_keep, mask_valid, mask
    );

    modport slave (
        input  opt_req, opt_line, opt_idx, cmp_we, cmp_line, cmp_src, cmp_dst,
               commit, commit_line, commit_count,
        output res_valid, res_keep, mask_valid, mask
    );
endinterface

// File: rtl/line_scheduler.sv
// Round-robin line scheduler for the nonogram solver: streams each pending line's options,
// compacts survivors in place, commits the reduced count and re-arms affected lines.
module line_scheduler #(
    parameter int SIZE   = 3,
    parameter int OPT_W  = 7,
    parameter int LINE_W = $clog2(2*SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2*SIZE*OPT_W-1:0]   init_count,
    line_scheduler_if.master          bus,
    output logic                      busy,
    output logic                      done,
    output logic                      solved,
    output logic                      fail,
    output logic [15:0]               lines_served
);
    localparam int NL = 2*SIZE;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_POP       = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT      = 3'd3;
    localparam logic [2:0] ST_COMMIT    = 3'd4;
    localparam logic [2:0] ST_WAIT_MASK = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_FAIL      = 3'd7;

    logic [2:0]        state_r, state_s;
    logic [OPT_W-1:0]  count_r [NL];
    logic [NL-1:0]     pending_r;
    logic [LINE_W-1:0] rr_r, cur_r, pick_s;
    logic [OPT_W-1:0]  rd_idx_r, wr_ptr_r, wr_next_s;
    logic              found_s, all_one_s, last_s;
    logic [NL-1:0]     cur_onehot_s;

    // Round-robin search: first pending line after the one served last.
    always_comb begin
        pick_s  = rr_r;
        found_s = 1'b0;
        for (int k = 1; k <= NL; k++) begin
            pick_s  = (!found_s && pending_r[(int'(rr_r) + k) % NL]) ? LINE_W'((int'(rr_r) + k) % NL) : pick_s;
            found_s = found_s | pending_r[(int'(rr_r) + k) % NL];
        end
    end

    // Solved means every line is down to exactly one option.
    always_comb begin
        all_one_s = 1'b1;
        for (int l = 0; l < NL; l++) begin
            all_one_s = all_one_s & (count_r[l] == OPT_W'(1));
        end
    end

    assign wr_next_s    = wr_ptr_r + {{(OPT_W-1){1'b0}}, bus.res_keep};
    assign last_s       = ((rd_idx_r + OPT_W'(1)) == count_r[cur_r]);
    assign cur_onehot_s = {{(NL-1){1'b0}}, 1'b1} << cur_r;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                state_s = start ? ST_POP : state_r;
            end
            ST_POP: begin
                if (!found_s) begin
                    state_s = ST_DONE;
                end else if (count_r[pick_s] == OPT_W'(0)) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.res_valid) begin
                    state_s = last_s ? ST_COMMIT : ST_ISSUE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_COMMIT: begin
                state_s = (wr_ptr_r == OPT_W'(0)) ? ST_FAIL : ST_WAIT_MASK;
            end
            ST_WAIT_MASK: begin
                state_s = bus.mask_valid ? ST_POP : state_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state, per-line bookkeeping and registered strobes/status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            pending_r        <= '0;
            rr_r             <= '0;
            cur_r            <= '0;
            rd_idx_r         <= '0;
            wr_ptr_r         <= '0;
            for (int l = 0; l < NL; l++) begin
                count_r[l] <= '0;
            end
            bus.opt_req      <= 1'b0;
            bus.opt_line     <= '0;
            bus.opt_idx      <= '0;
            bus.cmp_we       <= 1'b0;
            bus.cmp_line     <= '0;
            bus.cmp_src      <= '0;
            bus.cmp_dst      <= '0;
            bus.commit       <= 1'b0;
            bus.commit_line  <= '0;
            bus.commit_count <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            solved           <= 1'b0;
            fail             <= 1'b0;
            lines_served     <= 16'd0;
        end else begin
            state_r     <= state_s;
            bus.opt_req <= 1'b0;
            bus.cmp_we  <= 1'b0;
            bus.commit  <= 1'b0;
            busy        <= !((state_s == ST_IDLE) || (state_s == ST_DONE) || (state_s == ST_FAIL));
            done        <= (state_s == ST_DONE);
            fail        <= (state_s == ST_FAIL);
            case (state_r)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        for (int l = 0; l < NL; l++) begin
                            count_r[l] <= init_count[l*OPT_W +: OPT_W];
                        end
                        pending_r    <= '1;
                        rr_r         <= LINE_W'(NL-1);
                        lines_served <= 16'd0;
                        solved       <= 1'b0;
                    end
                end
                ST_POP: begin
                    if (found_s) begin
                        pending_r[pick_s] <= 1'b0;
                        rr_r              <= pick_s;
                        cur_r             <= pick_s;
                        rd_idx_r          <= '0;
                        wr_ptr_r          <= '0;
                        if (lines_served != 16'hFFFF) begin
                            lines_served <= lines_served + 16'd1;
                        end
                        if (count_r[pick_s] != OPT_W'(0)) begin
                            bus.opt_req  <= 1'b1;
                            bus.opt_line <= pick_s;
                            bus.opt_idx  <= '0;
                        end
                    end else begin
                        solved <= all_one_s;
                    end
                end
                ST_WAIT: begin
                    if (bus.res_valid) begin
                        // Survivors slide down over discarded slots; no copy when already in place.
                        if (bus.res_keep && (wr_ptr_r != rd_idx_r)) begin
                            bus.cmp_we   <= 1'b1;
                            bus.cmp_line <= cur_r;
                            bus.cmp_src  <= rd_idx_r;
                            bus.cmp_dst  <= wr_ptr_r;
                        end
                        rd_idx_r <= rd_idx_r + OPT_W'(1);
                        wr_ptr_r <= wr_next_s;
                        if (last_s) begin
                            count_r[cur_r]   <= wr_next_s;
                            bus.commit       <= 1'b1;
                            bus.commit_line  <= cur_r;
                            bus.commit_count <= wr_next_s;
                        end else begin
                            bus.opt_req  <= 1'b1;
                            bus.opt_line <= cur_r;
                            bus.opt_idx  <= rd_idx_r + OPT_W'(1);
                        end
                    end
                end
                ST_WAIT_MASK: begin
                    if (bus.mask_valid) begin
                        pending_r <= pending_r | (bus.mask & ~cur_onehot_s);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/line_scheduler.md
# line_scheduler

Work scheduler for the nonogram solver core. It holds the option count and a pending flag for each of the 2*SIZE lines, picks the next line round-robin, and streams that line's options one at a time from the option memory into the line-solver datapath. It compacts surviving options in place, commits the reduced count, and re-arms the lines the solver reports as affected. It runs until no line is pending (solved or stuck) or a line runs out of options (contradiction).

## Interface
Parameters:
- SIZE, 3, board side; lines 0..SIZE-1 are rows, SIZE..2*SIZE-1 are columns
- OPT_W, 7, width of option counts and option indices
- LINE_W, $clog2(2*SIZE), width of a line index

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a solve; honoured only in IDLE, DONE or FAIL
- init_count  in  2*SIZE x OPT_W  initial option count per line, packed, line L at [L]; sampled on start
- opt_req  out  1  one-cycle request to option memory
- opt_line  out  LINE_W  line of the requested option
- opt_idx  out  OPT_W  index of the requested option within the line
- res_valid  in  1  solver verdict for the outstanding option
- res_keep  in  1  1 = option consistent, 0 = contradicts and is discarded
- cmp_we  out  1  one-cycle option-memory copy strobe
- cmp_line  out  LINE_W  line being compacted
- cmp_src, cmp_dst  out  OPT_W each  copy option src to slot dst
- commit  out  1  one-cycle pulse: line finished, solver merges its known/assigned
- commit_line  out  LINE_W  line being committed
- commit_count  out  OPT_W  surviving option count for commit_line
- mask_valid  in  1  solver returns the affected-line mask after a commit
- mask  in  2*SIZE  bit L set = line L gained newly known cells
- busy, done, solved, fail  out  1 each  status
- lines_served  out  16  lines processed since start, saturating

## Operation
- Registered state per line: count[L] (OPT_W bits) and pending[L]. Scheduler registers: rr (last line served), cur, rd_idx, wr_ptr.
- States: IDLE, POP, ISSUE, WAIT, COMMIT, WAIT_MASK, DONE, FAIL.
- IDLE/DONE/FAIL + start: count <= init_count; pending <= all ones; rr <= 2*SIZE-1; lines_served <= 0; done, solved and fail cleared. Next state is POP.
- POP:
  - pending == 0: go to DONE. solved = 1 when every count == 1, else 0 (stuck).
  - Otherwise cur = first pending line searching rr+1, rr+2, ... wrapping modulo 2*SIZE. Clear pending[cur]; rr <= cur; rd_idx <= 0; wr_ptr <= 0; lines_served++ (saturating).
  - count[cur] == 0: go to FAIL. Otherwise go to ISSUE.
- ISSUE: opt_req = 1 for one cycle with opt_line = cur, opt_idx = rd_idx. Next state is WAIT.
- WAIT: res_valid is required; without it the block stays in WAIT.
  - On res_valid with res_keep = 1 and wr_ptr != rd_idx: cmp_we pulses next cycle with src = rd_idx, dst = wr_ptr.
  - On res_valid with res_keep = 1: wr_ptr++.
  - On every res_valid: rd_idx++.
  - If rd_idx+1 == count[cur], go to COMMIT; otherwise go to ISSUE.
- COMMIT: count[cur] <= wr_ptr. commit pulses with commit_line = cur and commit_count = wr_ptr. Go to FAIL if wr_ptr == 0, else WAIT_MASK.
- WAIT_MASK: on mask_valid, pending <= pending | (mask & ~onehot(cur)). Next state is POP.
- Only one option is ever outstanding.
- res_valid outside WAIT and mask_valid outside WAIT_MASK are ignored.
- start while busy is ignored.
- busy = 1 in every state except IDLE, DONE and FAIL. done = 1 in DONE. fail = 1 in FAIL.

## Timing
- Reset (async) sets state to IDLE. Every output is 0, count is 0, pending is 0, rr is 0. Reset mid-solve aborts immediately with no further strobes.
- All outputs are registered.
- start at edge t puts the block in POP at t+1. The first opt_req is high in cycle t+2.
- Per option: opt_req lasts 1 cycle. Response latency is unbounded (≥1 cycle). The next opt_req comes 1 cycle after res_valid.
- The cmp_we pulse coincides with the next opt_req or with commit.
- Per line overhead: POP 1 cycle, COMMIT 1 cycle, plus the mask latency.
- The count update and the commit pulse happen in the same cycle.
- Count widths are OPT_W throughout; wr_ptr ≤ rd_idx ≤ count never overflows.

## Test plan
- Reset mid-WAIT (SIZE=3) → all outputs 0 in the same cycle, state IDLE, a later start works normally.
- init_count all 1s, every res_keep=1, every mask=0 → six lines served in order 0..5, no cmp_we, DONE with solved=1, lines_served=6.
- Line 0 with count 4 and keeps 1,0,0,1 → cmp_we once with src=3, dst=1; commit_count=2; count[0]=2.
- Line 2 with count 3 and all keeps 0 → commit_count=0, then FAIL with fail=1 and busy=0. Also: init_count[4]=0 → FAIL when line 4 is popped.
- Mask 6'b000011 returned after line 3 → next line served is 4, then 5, then 0 and 1 re-served by wraparound.
- start pulsed during ISSUE → ignored. res_valid asserted in POP → no count change.
